// File: rtl/ternary_prng_sampler.sv
// Ternary / raw coefficient sampler built on a 32-bit xorshift generator.
// One xorshift step per cycle; the generated coefficients are streamed over a
// valid/ready handshake with an index. In ternary mode the 2-bit pattern 11 is
// rejected and counted. A run ends with a one-cycle done pulse after the last
// coefficient has been accepted.
module ternary_prng_sampler #(
    parameter int          WIDTH    = 13,
    parameter int          N        = 757,
    parameter int          IDX_W    = 10,
    parameter logic [31:0] ZERO_SUB = 32'h2545F491
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      seed,
    input  logic             mode,
    output logic             busy,
    output logic             coef_valid,
    input  logic             coef_ready,
    output logic [WIDTH-1:0] coef_data,
    output logic [IDX_W-1:0] coef_idx,
    output logic             done,
    output logic [15:0]      rej_cnt
);

    // The count is one bit wider than the index so that N itself is representable.
    localparam logic [IDX_W:0] N_C = (IDX_W + 1)'(N);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    fsm_t             fsm_r;
    logic [31:0]      state_r;
    logic [IDX_W:0]   count_r;
    logic             mode_r;

    logic [31:0]      next_state_s;
    logic [WIDTH-1:0] cand_value_s;
    logic             cand_reject_s;
    logic             adv_s;
    logic             finish_s;

    // xorshift32 step: shifts 13, 17, 5, all truncated to 32 bits.
    function automatic logic [31:0] xs_step(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 5'd13);
        t = t ^ (t >> 5'd17);
        t = t ^ (t << 5'd5);
        return t;
    endfunction

    // Next generator state, candidate coefficient and handshake/advance decisions.
    always_comb begin
        next_state_s  = xs_step(state_r);
        cand_value_s  = {WIDTH{1'b0}};
        cand_reject_s = 1'b0;
        if (mode_r) begin
            cand_value_s = next_state_s[WIDTH-1:0];
        end else begin
            case (next_state_s[1:0])
                2'b00:   cand_value_s = {WIDTH{1'b0}};
                2'b01:   cand_value_s = {{(WIDTH-1){1'b0}}, 1'b1};
                2'b10:   cand_value_s = {WIDTH{1'b1}};
                default: cand_reject_s = 1'b1;
            endcase
        end
        adv_s    = (fsm_r == ST_RUN) && (!coef_valid || coef_ready) && (count_r < N_C);
        finish_s = (fsm_r == ST_RUN) && (!coef_valid || coef_ready) && (count_r == N_C);
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r      <= ST_IDLE;
            state_r    <= 32'd0;
            count_r    <= '0;
            mode_r     <= 1'b0;
            busy       <= 1'b0;
            coef_valid <= 1'b0;
            coef_data  <= '0;
            coef_idx   <= '0;
            done       <= 1'b0;
            rej_cnt    <= 16'd0;
        end else begin
            case (fsm_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mode_r  <= mode;
                        state_r <= (seed == 32'd0) ? ZERO_SUB : seed;
                        count_r <= '0;
                        rej_cnt <= 16'd0;
                        busy    <= 1'b1;
                        fsm_r   <= ST_RUN;
                    end else begin
                        fsm_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (adv_s) begin
                        state_r <= next_state_s;
                        if (cand_reject_s) begin
                            coef_valid <= 1'b0;
                            if (rej_cnt != 16'hFFFF) begin
                                rej_cnt <= rej_cnt + 16'd1;
                            end else begin
                                rej_cnt <= rej_cnt;
                            end
                        end else begin
                            coef_valid <= 1'b1;
                            coef_data  <= cand_value_s;
                            coef_idx   <= count_r[IDX_W-1:0];
                            count_r    <= count_r + {{IDX_W{1'b0}}, 1'b1};
                        end
                    end else if (finish_s) begin
                        coef_valid <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        fsm_r      <= ST_DONE;
                    end else begin
                        // Stalled by the consumer: everything holds.
                        fsm_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    fsm_r <= ST_IDLE;
                end
                default: begin
                    fsm_r      <= ST_IDLE;
                    busy       <= 1'b0;
                    coef_valid <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ternary_prng_sampler.sv
// Scoreboard bench for ternary_prng_sampler: a software xorshift model pushes
// the expected coefficient stream, the monitor pops on every handshake.
module tb_ternary_prng_sampler;

    localparam int          WIDTH    = 13;
    localparam int          N        = 757;
    localparam int          IDX_W    = 10;
    localparam logic [31:0] ZERO_SUB = 32'h2545F491;
    localparam int          BUDGET   = 5000;

    logic             clk;
    logic             rst;
    logic             start;
    logic [31:0]      seed;
    logic             mode;
    logic             busy;
    logic             coef_valid;
    logic             coef_ready;
    logic [WIDTH-1:0] coef_data;
    logic [IDX_W-1:0] coef_idx;
    logic             done;
    logic [15:0]      rej_cnt;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks;
    int          n_fail;
    int          exp_rej;
    int          run_cycles;
    int          hs_count;
    logic [WIDTH-1:0] first_d[2];
    logic [IDX_W-1:0] first_i[2];
    int               first_c[2];

    ternary_prng_sampler #(
        .WIDTH(WIDTH), .N(N), .IDX_W(IDX_W), .ZERO_SUB(ZERO_SUB)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .mode(mode),
        .busy(busy), .coef_valid(coef_valid), .coef_ready(coef_ready),
        .coef_data(coef_data), .coef_idx(coef_idx), .done(done), .rej_cnt(rej_cnt)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_step(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    // Fill the scoreboard with the stream expected for this seed and mode.
    task automatic build_model(input logic [31:0] s, input logic md);
        logic [31:0] st;
        int          cnt;
        exp_t        e;
        exp_q.delete();
        exp_rej = 0;
        st  = (s == 32'd0) ? ZERO_SUB : s;
        cnt = 0;
        while (cnt < N) begin
            st = model_step(st);
            if (!md && st[1:0] == 2'b11) begin
                exp_rej++;
            end else begin
                e.idx = cnt[IDX_W-1:0];
                if (md)                  e.data = st[WIDTH-1:0];
                else if (st[1:0] == 2'b01) e.data = 13'h0001;
                else if (st[1:0] == 2'b10) e.data = 13'h1FFF;
                else                     e.data = 13'h0000;
                exp_q.push_back(e);
                cnt++;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"},  {31'd0, busy},       32'd0);
        check_val({tag, "_valid"}, {31'd0, coef_valid}, 32'd0);
        check_val({tag, "_data"},  {19'd0, coef_data},  32'd0);
        check_val({tag, "_idx"},   {22'd0, coef_idx},   32'd0);
        check_val({tag, "_done"},  {31'd0, done},       32'd0);
        check_val({tag, "_rej"},   {16'd0, rej_cnt},    32'd0);
    endtask

    // One run: start, monitor every handshake against the scoreboard, check
    // stall stability, done timing and rej_cnt. abort_idx >= 0 resets mid-run.
    task automatic run(input logic [31:0] s, input logic md, input bit rnd, input int abort_idx);
        exp_t             e;
        int               cyc;
        int               last_hs;
        bit               stalled;
        bit               finished;
        logic [WIDTH-1:0] hold_d;
        logic [IDX_W-1:0] hold_i;
        build_model(s, md);
        hs_count = 0;
        last_hs  = -10;
        stalled  = 1'b0;
        finished = 1'b0;
        @(negedge clk);
        seed = s; mode = md; start = 1'b1; coef_ready = 1'b1;
        cyc = 0;
        while (cyc < BUDGET && !finished) begin
            @(negedge clk);
            cyc++;
            if (rnd) begin
                start = 1'($urandom_range(0, 1));
                seed  = $urandom;
                mode  = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            if (done) begin
                start = 1'b0;
                finished = 1'b1;
                run_cycles = cyc;
                check_val("done_after_last_hs", cyc, last_hs + 1);
                check_val("busy_in_done", {31'd0, busy}, 32'd0);
                check_val("rej_cnt", {16'd0, rej_cnt}, exp_rej);
                check_val("hs_count", hs_count, N);
                check_val("scoreboard_empty", exp_q.size(), 0);
            end else begin
                coef_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (stalled) begin
                    check_val("stall_valid", {31'd0, coef_valid}, 32'd1);
                    check_val("stall_data", {19'd0, coef_data}, {19'd0, hold_d});
                    check_val("stall_idx", {22'd0, coef_idx}, {22'd0, hold_i});
                end
                if (coef_valid && coef_ready) begin
                    if (exp_q.size() == 0) begin
                        check_val("unexpected_hs", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("coef_idx", {22'd0, coef_idx}, {22'd0, e.idx});
                        check_val("coef_data", {19'd0, coef_data}, {19'd0, e.data});
                    end
                    if (hs_count < 2) begin
                        first_d[hs_count] = coef_data;
                        first_i[hs_count] = coef_idx;
                        first_c[hs_count] = cyc;
                    end
                    hs_count++;
                    last_hs = cyc;
                    if (abort_idx >= 0 && int'(coef_idx) == abort_idx) begin
                        rst = 1'b1;
                        #1;
                        check_reset_outputs("abort");
                        @(posedge clk);
                        #1;
                        check_reset_outputs("abort_hold");
                        @(negedge clk);
                        rst = 1'b0;
                        start = 1'b0;
                        coef_ready = 1'b1;
                        exp_q.delete();
                        return;
                    end
                end
                stalled = coef_valid && !coef_ready;
                hold_d  = coef_data;
                hold_i  = coef_idx;
            end
        end
        if (!finished) begin
            check_val("run_timeout", cyc, 32'd0);
            start = 1'b0;
        end else begin
            @(negedge clk);
            check_val("done_one_cycle", {31'd0, done}, 32'd0);
        end
        coef_ready = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; start = 1'b0; seed = 32'd0; mode = 1'b0; coef_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // seed=1 ternary: first two coefficients +1 at idx 0,1 on consecutive cycles.
        run(32'h1, 1'b0, 1'b0, -1);
        check_val("s1_first_data0", {19'd0, first_d[0]}, 32'h1);
        check_val("s1_first_data1", {19'd0, first_d[1]}, 32'h1);
        check_val("s1_first_idx1", {22'd0, first_i[1]}, 32'd1);
        check_val("s1_consecutive", first_c[1], first_c[0] + 1);

        // seed=1 raw: first coefficient is the low 13 bits of 0x00042021.
        run(32'h1, 1'b1, 1'b0, -1);
        check_val("raw_first_data", {19'd0, first_d[0]}, 32'h0021);
        check_val("raw_first_idx", {22'd0, first_i[0]}, 32'd0);

        // seed=0 substitutes ZERO_SUB.
        run(32'h0, 1'b0, 1'b0, -1);

        // Full ternary run with exact cycle count.
        run(32'hDEADBEEF, 1'b0, 1'b0, -1);
        check_val("cycle_count", run_cycles, N + exp_rej + 2);

        // Same seed under random backpressure and junk start/seed/mode inputs.
        run(32'hDEADBEEF, 1'b0, 1'b1, -1);
        run(32'h12345678, 1'b1, 1'b1, -1);

        // Abort at idx 300, then the same seed reproduces from idx 0.
        run(32'hDEADBEEF, 1'b0, 1'b0, 300);
        repeat (2) @(negedge clk);
        run(32'hDEADBEEF, 1'b0, 1'b0, -1);
        check_val("post_abort_cycles", run_cycles, N + exp_rej + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ternary_prng_sampler.md
Name: ternary_prng_sampler

Overview:
- Sequential, parametrised successor to the combinational xorshift coefficient generator.
- Holds a 32-bit xorshift state register and streams N small-polynomial coefficients over a valid/ready interface, one step per cycle.
- Two modes: ternary {-1,0,+1} with rejection of one 2-bit pattern, or raw uniform WIDTH-bit values.
- Feeds coefficient RAM / multiplier front-end of the SNTRUP757 datapath.

Parameters:
- WIDTH, 13, coefficient width; two's-complement output.
- N, 757, coefficients per run.
- IDX_W, 10, index/counter width; must satisfy 2^IDX_W >= N.
- ZERO_SUB, 32'h2545F491, state loaded when seed == 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- seed  in  32  seed, latched on accepted start.
- mode  in  1  0 = ternary, 1 = raw; latched on accepted start.
- busy  out  1  high in RUN.
- coef_valid  out  1  coef_data/coef_idx valid.
- coef_ready  in  1  consumer accepts when coef_valid & coef_ready.
- coef_data  out  WIDTH  coefficient.
- coef_idx  out  IDX_W  index 0..N-1 of coef_data.
- done  out  1  one-cycle pulse after the last coefficient is accepted.
- rej_cnt  out  16  rejections in current/last run; saturates at 16'hFFFF.

Behaviour:
- Reset (async, any state): FSM=IDLE, state reg=0, count=0, busy=0, coef_valid=0, coef_data=0, coef_idx=0, done=0, rej_cnt=0.
- Step function f(x), 32-bit, in order:
  - x ^= x<<13
  - x ^= x>>17
  - x ^= x<<5
  - All arithmetic is truncated to 32 bits.
- IDLE:
  - start=1 latches mode, loads state = (seed==0 ? ZERO_SUB : seed), clears count and rej_cnt, and moves to RUN next cycle.
  - done=0.
- RUN, advance condition: adv = (!coef_valid | coef_ready) & (count < N).
- RUN, on adv: state <= f(state). Candidate c = f(state) of the current state, i.e. the new value.
- Ternary mode, c[1:0]:
  - 00 -> 0
  - 01 -> +1 (13'h0001)
  - 10 -> -1 (all ones)
  - 11 -> reject: coef_valid<=0, rej_cnt++ (saturating), count unchanged.
- Raw mode: c[WIDTH-1:0] is always accepted.
- On accept: coef_valid<=1, coef_data<=value, coef_idx<=count, count<=count+1.
- Latency: first candidate one cycle after entering RUN. Max throughput 1 coefficient/cycle with coef_ready held high.
- Backpressure: while coef_valid & !coef_ready, hold coef_data, coef_idx and the state register stable; no step taken.
- If coef_valid & coef_ready and count==N: coef_valid<=0, and go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
  - coef_data/coef_idx keep their last values.
  - rej_cnt holds until the next start.
- start during RUN/DONE is ignored; seed and mode changes outside IDLE have no effect.
- Reset mid-run aborts immediately to IDLE with all outputs at reset values. No done pulse.
- coef_idx wraps never; the run ends at N-1.

Test Plan:
- Ternary, seed=32'h1, coef_ready=1:
  - state sequence 0x00042021, 0x04080601.
  - first two outputs coef_data=13'h0001 at coef_idx 0 and 1, in consecutive cycles.
- Raw mode, seed=32'h1: first output coef_data=13'h0021, idx 0.
- seed=0: state after load equals 32'h2545F491. The first candidate is f(32'h2545F491), matching a software model over all N outputs.
- Full run, ternary, seed=32'hDEADBEEF, coef_ready=1:
  - exactly 757 handshakes with idx 0..756 in order, all values in {0,1,1FFF};
  - done pulses once, one cycle after the handshake at idx 756;
  - rej_cnt equals the software-model rejection count;
  - cycle count from start to done = 757 + rej_cnt + 2.
- Backpressure: random coef_ready (≈50%) -> data/idx stable while stalled; output sequence identical to the coef_ready=1 run.
- Reset asserted at idx 300 -> outputs return to 0 asynchronously (same cycle); a new start with the same seed reproduces the sequence from idx 0.
